// File: rtl/uart_frame_parser_if.sv
// ============================================================================
// Module      : uart_frame_parser_if
// Description : Byte-in / payload-out signal bundle for uart_frame_parser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_frame_parser_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [7:0] m_len;
    logic       csum_err;
    logic       len_err;
    logic       ovr_err;
    logic       to_err;

    // master: UART receiver plus downstream decoder side
    modport master (
        output rx_done_tick, rx_data, m_ready,
        input  m_valid, m_data, m_last, m_len, csum_err, len_err, ovr_err, to_err
    );

    // slave: the frame parser itself
    modport slave (
        input  rx_done_tick, rx_data, m_ready,
        output m_valid, m_data, m_last, m_len, csum_err, len_err, ovr_err, to_err
    );
endinterface

`default_nettype wire

// File: rtl/uart_frame_parser.sv
// ============================================================================
// Module      : uart_frame_parser
// Description : Parses SYNC/LEN/payload/XOR-checksum frames and replays good
//               payloads on a valid/ready stream. Optional inter-byte timeout
//               enabled by defining UART_FRAME_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_parser #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    uart_frame_parser_if.slave bus
);
    localparam int c_PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [7:0]      r_len;
    logic [7:0]      r_csum;
    logic [7:0]      r_buf [MAX_LEN];
    logic            r_valid;
    logic            r_last;
    logic [7:0]      r_data;
    logic [7:0]      r_m_len;
    logic            r_csum_err;
    logic            r_len_err;
    logic            r_ovr_err;

    logic            w_tick;
    logic            w_wr_en;
    logic            w_xfer;
    logic            w_len_ok;
    logic [7:0]      w_len_m1;
    logic [c_PW-1:0] w_rd_next;

    assign w_tick    = bus.rx_done_tick;
    assign w_wr_en   = (r_state == S_PAYLOAD) && w_tick;
    assign w_xfer    = r_valid && bus.m_ready;
    assign w_len_ok  = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_LEN));
    assign w_len_m1  = r_len - 8'd1;
    assign w_rd_next = r_rd_ptr + c_PW'(1);

    // Marks unsupported parameter sets in the elaborated hierarchy.
    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 2) begin : g_param_out_of_range
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int c_TW = ($clog2(TIMEOUT_CYC) > 17) ? $clog2(TIMEOUT_CYC) : 17;

    logic [c_TW-1:0] r_to_cnt;
    logic            r_to_err;
    logic            w_in_frame;
    logic            w_expire;

    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign w_expire   = w_in_frame && !w_tick && (r_to_cnt == c_TW'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_HUNT;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_len      <= 8'd0;
            r_csum     <= 8'd0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= 8'd0;
            r_m_len    <= 8'd0;
            r_csum_err <= 1'b0;
            r_len_err  <= 1'b0;
            r_ovr_err  <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_to_err   <= 1'b0;
`endif
        end else begin
            r_csum_err <= 1'b0;
            r_len_err  <= 1'b0;
            r_ovr_err  <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            r_to_err   <= 1'b0;
            r_to_cnt   <= (w_tick || !w_in_frame || w_expire) ? '0 : r_to_cnt + c_TW'(1);
            if (w_expire) begin
                r_to_err <= 1'b1;
                r_state  <= S_HUNT;
            end else
`endif
            case (r_state)
                S_HUNT: begin
                    if (w_tick && bus.rx_data == SYNC_BYTE) begin
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_tick) begin
                        if (w_len_ok) begin
                            r_len    <= bus.rx_data;
                            r_csum   <= bus.rx_data;
                            r_wr_ptr <= '0;
                            r_state  <= S_PAYLOAD;
                        end else begin
                            r_len_err <= 1'b1;
                            r_state   <= S_HUNT;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_tick) begin
                        r_csum <= r_csum ^ bus.rx_data;
                        // Pointer parks on the last slot so it never wraps at MAX_LEN.
                        if (8'(r_wr_ptr) == w_len_m1) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_PW'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (w_tick) begin
                        if (bus.rx_data == r_csum) begin
                            r_rd_ptr <= '0;
                            r_valid  <= 1'b1;
                            r_data   <= r_buf[0];
                            r_last   <= (r_len == 8'd1);
                            r_m_len  <= r_len;
                            r_state  <= S_OUT;
                        end else begin
                            r_csum_err <= 1'b1;
                            r_state    <= S_HUNT;
                        end
                    end
                end
                S_OUT: begin
                    if (w_tick) begin
                        r_ovr_err <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_data  <= 8'd0;
                            r_m_len <= 8'd0;
                            r_state <= S_HUNT;
                        end else begin
                            r_rd_ptr <= w_rd_next;
                            r_data   <= r_buf[w_rd_next];
                            r_last   <= (8'(w_rd_next) == w_len_m1);
                        end
                    end
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign bus.m_valid  = r_valid;
    assign bus.m_data   = r_data;
    assign bus.m_last   = r_last;
    assign bus.m_len    = r_m_len;
    assign bus.csum_err = r_csum_err;
    assign bus.len_err  = r_len_err;
    assign bus.ovr_err  = r_ovr_err;
`ifdef UART_FRAME_TIMEOUT_EN
    assign bus.to_err   = r_to_err;
`else
    assign bus.to_err   = 1'b0;
`endif

endmodule

`default_nettype wire
